// File: rtl/aes_multiblock_ctrl_pkg.sv
`default_nettype none
// ---- aes_multiblock_ctrl_pkg: FSM states and block geometry for the AES multi-block controller (rev 1.0)
package aes_multiblock_ctrl_pkg;

  localparam int AES_BLOCK_BITS = 128;

  typedef enum logic [2:0] {
    MB_IDLE     = 3'd0,
    MB_STARTING = 3'd1,
    MB_WORKING  = 3'd2,
    MB_DRAIN    = 3'd3,
    MB_FINISHED = 3'd4,
    MB_ERROR    = 3'd5
  } aes_mblk_state_t;

  function automatic int aes_words_per_block(input int data_w);
    return AES_BLOCK_BITS / data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_multiblock_ctrl_watchdog.sv
`default_nettype none
// ---- aes_multiblock_ctrl_watchdog: idle-cycle counter, expires on the TIMEOUT-th tick after a load (rev 1.0)
module aes_multiblock_ctrl_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic load_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = '0;
    else if (tick_i && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else if (clear_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // A load in the same cycle wins: a handshake always rescues the job.
  assign expire_o = tick_i && !load_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/aes_multiblock_ctrl.sv
`default_nettype none
// ---- aes_multiblock_ctrl: job-level control for streaming N AES blocks through the engine (rev 1.0)
module aes_multiblock_ctrl
  import aes_multiblock_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NBLK_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [31:0]       src_base_i,
  input  logic [31:0]       dst_base_i,
  input  logic [NBLK_W-1:0] nblk_i,
  input  logic              decrypt_i,
  input  logic              src_ready_start_i,
  input  logic              snk_ready_start_i,
  input  logic              snk_done_i,
  input  logic              eng_out_hs_i,
  output logic              src_req_start_o,
  output logic              snk_req_start_o,
  output logic [31:0]       src_base_o,
  output logic [31:0]       dst_base_o,
  output logic [NBLK_W+2:0] trans_size_o,
  output logic              eng_clear_o,
  output logic              eng_start_o,
  output logic              eng_decrypt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [NBLK_W-1:0] blk_cnt_o
);

  localparam int WPB_LOG2 = $clog2(aes_words_per_block(DATA_W));

  aes_mblk_state_t   state_q, state_d;
  logic [31:0]       src_base_q, src_base_d;
  logic [31:0]       dst_base_q, dst_base_d;
  logic [NBLK_W-1:0] nblk_q, nblk_d;
  logic [NBLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic              decrypt_q, decrypt_d;
  logic              wd_load, wd_tick, wd_expire;

  always_comb begin
    state_d         = state_q;
    src_base_d      = src_base_q;
    dst_base_d      = dst_base_q;
    nblk_d          = nblk_q;
    blk_cnt_d       = blk_cnt_q;
    decrypt_d       = decrypt_q;
    src_req_start_o = 1'b0;
    snk_req_start_o = 1'b0;
    eng_start_o     = 1'b0;
    eng_clear_o     = 1'b0;
    done_o          = 1'b0;
    err_o           = 1'b0;
    wd_load         = 1'b1;
    wd_tick         = 1'b0;

    case (state_q)
      MB_IDLE: begin
        eng_clear_o = 1'b1;
        if (start_i) begin
          src_base_d = src_base_i;
          dst_base_d = dst_base_i;
          nblk_d     = nblk_i;
          decrypt_d  = decrypt_i;
          blk_cnt_d  = '0;
          state_d    = (nblk_i == '0) ? MB_FINISHED : MB_STARTING;
        end
      end
      MB_STARTING: begin
        src_req_start_o = 1'b1;
        snk_req_start_o = 1'b1;
        eng_start_o     = 1'b1;
        if (src_ready_start_i && snk_ready_start_i)
          state_d = MB_WORKING;
      end
      MB_WORKING: begin
        wd_tick = 1'b1;
        wd_load = eng_out_hs_i;
        if (eng_out_hs_i) begin
          blk_cnt_d = blk_cnt_q + 1'b1;
          if (blk_cnt_q == nblk_q - 1'b1)
            state_d = MB_DRAIN;
        end else if (wd_expire) begin
          state_d = MB_ERROR;
        end
      end
      MB_DRAIN: begin
        // Engine is done; only the sink write-back completion matters now.
        wd_tick = 1'b1;
        wd_load = 1'b0;
        if (snk_done_i)
          state_d = MB_FINISHED;
        else if (wd_expire)
          state_d = MB_ERROR;
      end
      MB_FINISHED: begin
        done_o  = 1'b1;
        state_d = MB_IDLE;
      end
      MB_ERROR: begin
        err_o       = 1'b1;
        eng_clear_o = 1'b1;
        state_d     = MB_IDLE;
      end
      default: state_d = MB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= MB_IDLE;
      src_base_q <= '0;
      dst_base_q <= '0;
      nblk_q     <= '0;
      blk_cnt_q  <= '0;
      decrypt_q  <= 1'b0;
    end else if (clear_i) begin
      state_q    <= MB_IDLE;
      src_base_q <= '0;
      dst_base_q <= '0;
      nblk_q     <= '0;
      blk_cnt_q  <= '0;
      decrypt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      nblk_q     <= nblk_d;
      blk_cnt_q  <= blk_cnt_d;
      decrypt_q  <= decrypt_d;
    end
  end

  aes_multiblock_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (clear_i),
    .load_i   (wd_load),
    .tick_i   (wd_tick),
    .expire_o (wd_expire)
  );

  assign src_base_o    = src_base_q;
  assign dst_base_o    = dst_base_q;
  assign trans_size_o  = {3'b000, nblk_q} << WPB_LOG2;
  assign eng_decrypt_o = decrypt_q;
  assign busy_o        = (state_q != MB_IDLE);
  assign blk_cnt_o     = blk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_multiblock_ctrl.sv
`default_nettype none
// ---- tb_aes_multiblock_ctrl: directed self-checking bench for aes_multiblock_ctrl (rev 1.0)
module tb_aes_multiblock_ctrl;

  localparam int NBLK_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear_i = 1'b0;
  logic              start_i = 1'b0;
  logic [31:0]       src_base_i = '0;
  logic [31:0]       dst_base_i = '0;
  logic [NBLK_W-1:0] nblk_i = '0;
  logic              decrypt_i = 1'b0;
  logic              src_ready_start_i = 1'b0;
  logic              snk_ready_start_i = 1'b0;
  logic              snk_done_i = 1'b0;
  logic              eng_out_hs_i = 1'b0;
  logic              src_req_start_o, snk_req_start_o;
  logic [31:0]       src_base_o, dst_base_o;
  logic [NBLK_W+2:0] trans_size_o;
  logic              eng_clear_o, eng_start_o, eng_decrypt_o;
  logic              busy_o, done_o, err_o;
  logic [NBLK_W-1:0] blk_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  aes_multiblock_ctrl #(
    .DATA_W  (32),
    .NBLK_W  (NBLK_W),
    .TIMEOUT (16)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .clear_i           (clear_i),
    .start_i           (start_i),
    .src_base_i        (src_base_i),
    .dst_base_i        (dst_base_i),
    .nblk_i            (nblk_i),
    .decrypt_i         (decrypt_i),
    .src_ready_start_i (src_ready_start_i),
    .snk_ready_start_i (snk_ready_start_i),
    .snk_done_i        (snk_done_i),
    .eng_out_hs_i      (eng_out_hs_i),
    .src_req_start_o   (src_req_start_o),
    .snk_req_start_o   (snk_req_start_o),
    .src_base_o        (src_base_o),
    .dst_base_o        (dst_base_o),
    .trans_size_o      (trans_size_o),
    .eng_clear_o       (eng_clear_o),
    .eng_start_o       (eng_start_o),
    .eng_decrypt_o     (eng_decrypt_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .blk_cnt_o         (blk_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [NBLK_W-1:0] n, input logic [31:0] sb,
                        input logic [31:0] db, input logic dec);
    start_i = 1'b1; nblk_i = n; src_base_i = sb; dst_base_i = db; decrypt_i = dec;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_eng_clear", {31'd0, eng_clear_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_src_req", {31'd0, src_req_start_o}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rst_blk_cnt", {16'd0, blk_cnt_o}, 32'd0);
    chk("rst_trans_size", {13'd0, trans_size_o}, 32'd0);
    chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);

    // 4-block decrypt job, streamers ready immediately
    src_ready_start_i = 1'b1; snk_ready_start_i = 1'b1;
    launch(16'd4, 32'h0000_1000, 32'h0000_2000, 1'b1);
    chk("a_src_req", {31'd0, src_req_start_o}, 32'd1);
    chk("a_snk_req", {31'd0, snk_req_start_o}, 32'd1);
    chk("a_eng_start", {31'd0, eng_start_o}, 32'd1);
    chk("a_eng_clear", {31'd0, eng_clear_o}, 32'd0);
    chk("a_trans_size", {13'd0, trans_size_o}, 32'd16);
    chk("a_src_base", src_base_o, 32'h0000_1000);
    chk("a_dst_base", dst_base_o, 32'h0000_2000);
    chk("a_decrypt", {31'd0, eng_decrypt_o}, 32'd1);
    step();
    chk("a_req_drop", {31'd0, src_req_start_o}, 32'd0);
    chk("a_busy", {31'd0, busy_o}, 32'd1);
    eng_out_hs_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("a_blk_cnt4", {16'd0, blk_cnt_o}, 32'd4);
    step(); // DRAIN: handshake ignored
    eng_out_hs_i = 1'b0;
    chk("a_drain_hs_ignored", {16'd0, blk_cnt_o}, 32'd4);
    chk("a_drain_no_done", {31'd0, done_o}, 32'd0);
    snk_done_i = 1'b1;
    step();
    snk_done_i = 1'b0;
    chk("a_done", {31'd0, done_o}, 32'd1);
    step();
    chk("a_done_pulse", {31'd0, done_o}, 32'd0);
    chk("a_idle", {31'd0, busy_o}, 32'd0);
    chk("a_blk_hold", {16'd0, blk_cnt_o}, 32'd4);

    // zero-block job
    launch(16'd0, 32'h0000_3000, 32'h0000_4000, 1'b0);
    chk("b_done", {31'd0, done_o}, 32'd1);
    chk("b_no_req", {30'd0, src_req_start_o, eng_start_o}, 32'd0);
    chk("b_blk_zeroed", {16'd0, blk_cnt_o}, 32'd0);
    step();
    chk("b_idle", {30'd0, busy_o, done_o}, 32'd0);

    // sink streamer ready 5 cycles late
    snk_ready_start_i = 1'b0;
    launch(16'd2, 32'h0000_5000, 32'h0000_6000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("c_req_hold%0d", k), {30'd0, src_req_start_o, snk_req_start_o}, 32'd3);
      if (k == 5) snk_ready_start_i = 1'b1;
      step();
    end
    chk("c_req_drop", {30'd0, src_req_start_o, eng_start_o}, 32'd0);
    eng_out_hs_i = 1'b1;
    step(); step();
    eng_out_hs_i = 1'b0;
    snk_done_i = 1'b1;
    step();
    snk_done_i = 1'b0;
    chk("c_done", {31'd0, done_o}, 32'd1);
    chk("c_blk_cnt", {16'd0, blk_cnt_o}, 32'd2);
    step();

    // watchdog: stall after one handshake
    launch(16'd3, 32'h0000_7000, 32'h0000_8000, 1'b0);
    step();
    eng_out_hs_i = 1'b1;
    step();
    eng_out_hs_i = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      chk($sformatf("d_no_err%0d", k), {31'd0, err_o}, 32'd0);
    end
    step();
    chk("d_err", {31'd0, err_o}, 32'd1);
    chk("d_err_clear", {31'd0, eng_clear_o}, 32'd1);
    chk("d_err_blk", {16'd0, blk_cnt_o}, 32'd1);
    step();
    chk("d_err_pulse", {31'd0, err_o}, 32'd0);
    chk("d_idle", {31'd0, busy_o}, 32'd0);
    chk("d_blk_hold", {16'd0, blk_cnt_o}, 32'd1);

    // synchronous clear mid-job at block 2
    launch(16'd4, 32'h0000_9000, 32'h0000_A000, 1'b1);
    step();
    eng_out_hs_i = 1'b1;
    step(); step();
    eng_out_hs_i = 1'b0;
    chk("e_blk2", {16'd0, blk_cnt_o}, 32'd2);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("e_busy", {31'd0, busy_o}, 32'd0);
    chk("e_blk", {16'd0, blk_cnt_o}, 32'd0);
    chk("e_src_base", src_base_o, 32'd0);
    chk("e_trans_size", {13'd0, trans_size_o}, 32'd0);
    chk("e_decrypt", {31'd0, eng_decrypt_o}, 32'd0);
    chk("e_eng_clear", {31'd0, eng_clear_o}, 32'd1);
    chk("e_no_pulse", {30'd0, done_o, err_o}, 32'd0);
    step();
    chk("e_no_pulse_late", {30'd0, done_o, err_o}, 32'd0);

    // start and snk_done during WORKING are ignored
    launch(16'd2, 32'h0000_B000, 32'h0000_C000, 1'b0);
    step();
    start_i = 1'b1; nblk_i = 16'd5; src_base_i = 32'hDEAD_0000;
    snk_done_i = 1'b1;
    step();
    start_i = 1'b0; snk_done_i = 1'b0;
    chk("f_trans_kept", {13'd0, trans_size_o}, 32'd8);
    chk("f_src_kept", src_base_o, 32'h0000_B000);
    chk("f_still_busy", {30'd0, busy_o, done_o}, 32'd2);
    eng_out_hs_i = 1'b1;
    step(); step();
    eng_out_hs_i = 1'b0;
    chk("f_blk2", {16'd0, blk_cnt_o}, 32'd2);
    snk_done_i = 1'b1;
    step();
    snk_done_i = 1'b0;
    chk("f_done", {31'd0, done_o}, 32'd1);
    chk("f_blk_final", {16'd0, blk_cnt_o}, 32'd2);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
